dmem_arbiter: RTL

Shares the single-port data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/loader). Grants at most one access per cycle, drives the memory's write-enable/address/unit-size/write-data inputs, and returns registered responses one cycle after the grant. Supports round-robin or fixed priority, a bus lock for atomic multi-access sequences with timeout release, and error responses for misaligned or out-of-range accesses.

---
 rtl/dmem_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU load/store
// unit (port 0) and the debug/loader port (port 1). At most one access is
// granted per cycle. The response for each grant comes back one cycle later.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DMEM_BYTES     = 4096,
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned LOCK_TIMEOUT   = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    // Port 0: CPU load/store unit
    input  logic                  p0Req,
    input  logic                  p0Lock,
    input  logic                  p0WriteEnable,
    input  logic [ADDR_WIDTH-1:0] p0Addr,
    input  logic [2:0]            p0UnitSize,
    input  logic [DATA_WIDTH-1:0] p0WriteData,
    output logic                  p0Gnt,
    output logic                  p0RValid,
    output logic [DATA_WIDTH-1:0] p0RData,
    output logic                  p0Err,

    // Port 1: debug / loader
    input  logic                  p1Req,
    input  logic                  p1Lock,
    input  logic                  p1WriteEnable,
    input  logic [ADDR_WIDTH-1:0] p1Addr,
    input  logic [2:0]            p1UnitSize,
    input  logic [DATA_WIDTH-1:0] p1WriteData,
    output logic                  p1Gnt,
    output logic                  p1RValid,
    output logic [DATA_WIDTH-1:0] p1RData,
    output logic                  p1Err,

    // Memory side
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [2:0]            memUnitSize,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    typedef enum logic [1:0] {
        StOpen,
        StLock0,
        StLock1
    } state_e;

    localparam logic [7:0] LockLimit = 8'(LOCK_TIMEOUT);

    state_e     state_q;
    logic       last_grant_q;   // port granted most recently (1 = port 1)
    logic [7:0] lock_cnt_q;     // idle cycles of the lock owner
    logic [7:0] lock_cnt_inc;

    logic                  gnt0;
    logic                  gnt1;
    logic                  any_gnt;

    logic                  sel_we;
    logic                  sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]            sel_size;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  size_ok;
    logic                  align_ok;
    logic                  range_ok;
    logic [2:0]            access_bytes;
    logic [63:0]           end_addr;
    logic                  sel_err;

    assign lock_cnt_inc = lock_cnt_q + 8'd1;

    // Grant decision: lock ownership first, then fixed priority or round-robin.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            case (state_q)
                StLock0: gnt0 = p0Req;
                StLock1: gnt1 = p1Req;
                default: begin
                    if (p0Req && p1Req) begin
                        // Round-robin: the port not granted last time wins the tie.
                        if ((FIXED_PRIORITY != 0) || last_grant_q) begin
                            gnt0 = 1'b1;
                        end else begin
                            gnt1 = 1'b1;
                        end
                    end else begin
                        gnt0 = p0Req;
                        gnt1 = p1Req;
                    end
                end
            endcase
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign p0Gnt   = gnt0;
    assign p1Gnt   = gnt1;

    // Route the granted port's request fields; all zero when nothing is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_size  = '0;
        sel_wdata = '0;
        if (gnt0) begin
            sel_we    = p0WriteEnable;
            sel_lock  = p0Lock;
            sel_addr  = p0Addr;
            sel_size  = p0UnitSize;
            sel_wdata = p0WriteData;
        end else if (gnt1) begin
            sel_we    = p1WriteEnable;
            sel_lock  = p1Lock;
            sel_addr  = p1Addr;
            sel_size  = p1UnitSize;
            sel_wdata = p1WriteData;
        end
    end

    // Validity of the granted access: legal size, natural alignment, in range.
    always_comb begin
        size_ok      = 1'b1;
        align_ok     = 1'b1;
        access_bytes = 3'd4;
        case (sel_size)
            3'b000, 3'b100: begin
                access_bytes = 3'd1;
            end
            3'b001, 3'b101: begin
                access_bytes = 3'd2;
                align_ok     = ~sel_addr[0];
            end
            3'b010: begin
                access_bytes = 3'd4;
                align_ok     = (sel_addr[1:0] == 2'b00);
            end
            default: begin
                size_ok = 1'b0;
            end
        endcase
        // Widened so that addresses near the top of the space cannot wrap.
        end_addr = 64'(sel_addr) + 64'(access_bytes);
        range_ok = (end_addr <= 64'(DMEM_BYTES));
        sel_err  = ~(size_ok & align_ok & range_ok);
    end

    // Memory drive: an erroneous store must never reach the array.
    assign memWriteEnable = any_gnt & sel_we & ~sel_err;
    assign memAddr        = sel_addr;
    assign memUnitSize    = sel_size;
    assign memWriteData   = sel_wdata;

    // Arbiter FSM, round-robin history, lock timeout and registered responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StOpen;
            last_grant_q <= 1'b1;
            lock_cnt_q   <= '0;
            p0RValid     <= 1'b0;
            p1RValid     <= 1'b0;
            p0Err        <= 1'b0;
            p1Err        <= 1'b0;
            p0RData      <= '0;
            p1RData      <= '0;
        end else begin
            // Responses: one-cycle pulse for every grant, data only for good loads.
            p0RValid <= gnt0;
            p1RValid <= gnt1;
            p0Err    <= gnt0 & sel_err;
            p1Err    <= gnt1 & sel_err;
            p0RData  <= (gnt0 && !sel_we && !sel_err) ? memReadData : '0;
            p1RData  <= (gnt1 && !sel_we && !sel_err) ? memReadData : '0;

            if (any_gnt) begin
                last_grant_q <= gnt1;
            end

            case (state_q)
                StOpen: begin
                    lock_cnt_q <= '0;
                    if (gnt0 && sel_lock) begin
                        state_q <= StLock0;
                    end else if (gnt1 && sel_lock) begin
                        state_q <= StLock1;
                    end
                end
                StLock0: begin
                    if (gnt0) begin
                        lock_cnt_q <= '0;
                        if (!sel_lock) begin
                            state_q <= StOpen;
                        end
                    end else if (lock_cnt_inc >= LockLimit) begin
                        // Owner went quiet for too long: free the bus.
                        lock_cnt_q <= '0;
                        state_q    <= StOpen;
                    end else begin
                        lock_cnt_q <= lock_cnt_inc;
                    end
                end
                StLock1: begin
                    if (gnt1) begin
                        lock_cnt_q <= '0;
                        if (!sel_lock) begin
                            state_q <= StOpen;
                        end
                    end else if (lock_cnt_inc >= LockLimit) begin
                        lock_cnt_q <= '0;
                        state_q    <= StOpen;
                    end else begin
                        lock_cnt_q <= lock_cnt_inc;
                    end
                end
                default: begin
                    lock_cnt_q <= '0;
                    state_q    <= StOpen;
                end
            endcase
        end
    end

endmodule
